// File: rtl/bch_pkg.sv
// Shared constants, state/source encodings and the polynomial-division step
// for the BCH(31,21) double-error-correcting parity/syndrome datapath.
package bch_pkg;

   localparam int N     = 31;
   localparam int K     = 21;
   localparam int PAR_W = 10;
   localparam logic [PAR_W:0] G_POLY = 11'h769;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      HOLD = 2'd2
   } state_t;

   typedef enum logic {
      SRC_ENC = 1'b0,
      SRC_CHK = 1'b1
   } src_t;

   // One long-division step: shift the next operand bit in, reduce by g(x).
   function automatic logic [PAR_W-1:0] rem_step(input logic [PAR_W-1:0] rem,
                                                 input logic             bit_in);
      logic [PAR_W:0] acc;
      acc = {rem, bit_in};
      if (acc[PAR_W]) begin
         acc = acc ^ G_POLY;
      end else begin
         acc = acc;
      end
      return acc[PAR_W-1:0];
   endfunction

endpackage

// File: rtl/enc_synd_calc_enc.sv
// Combinational remainder of a P_D_WIDTH-bit operand modulo g(x), MSB first.
// Fed {data, 10'b0} it yields systematic parity; fed a received word, its syndrome.
module enc_synd_calc_enc
   import bch_pkg::*;
#(
   parameter int P_D_WIDTH = 31
) (
   input  logic [P_D_WIDTH-1:0] opnd,
   output logic [PAR_W-1:0]     rem
);

   logic [PAR_W-1:0] rem_s;

   // Unrolled long division over every operand bit.
   always_comb begin
      rem_s = '0;
      for (int i = P_D_WIDTH - 1; i >= 0; i--) begin
         rem_s = rem_step(rem_s, opnd[i]);
      end
   end

   assign rem = rem_s;

endmodule

// File: rtl/bch_enc_synd_arb.sv
// Arbitrates an encode port and a check port onto one shared BCH(31,21)
// remainder core; registers operands/results and keeps saturating statistics.
module bch_enc_synd_arb
   import bch_pkg::*;
#(
   parameter int P_CNT_W    = 16,
   parameter int P_ARB_MODE = 0
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               enc_req_i,
   input  logic [K-1:0]       enc_dat_i,
   output logic               enc_ack_o,
   input  logic               chk_req_i,
   input  logic [N-1:0]       chk_dat_i,
   output logic               chk_ack_o,
   output logic               res_vld_o,
   input  logic               res_rdy_i,
   output logic               res_src_o,
   output logic [N-1:0]       res_dat_o,
   output logic [PAR_W-1:0]   res_synd_o,
   output logic               res_err_o,
   output logic               busy_o,
   input  logic               cnt_clr_i,
   output logic [P_CNT_W-1:0] enc_cnt_o,
   output logic [P_CNT_W-1:0] err_cnt_o
);

   localparam logic [P_CNT_W-1:0] CNT_ONE = P_CNT_W'(1);
   localparam logic [P_CNT_W-1:0] CNT_MAX = '1;

   state_t             state_r;
   state_t             state_nxt_s;
   logic               last_chk_r;
   logic               pick_chk_s;
   logic               gnt_s;
   logic               hs_s;
   logic [N-1:0]       opnd_r;
   src_t               src_r;
   logic [PAR_W-1:0]   core_rem_s;
   src_t               res_src_r;
   logic [N-1:0]       res_dat_r;
   logic [PAR_W-1:0]   res_synd_r;
   logic               res_err_r;
   logic [P_CNT_W-1:0] enc_cnt_r;
   logic [P_CNT_W-1:0] err_cnt_r;

   enc_synd_calc_enc #(
      .P_D_WIDTH (N)
   ) u_calc (
      .opnd (opnd_r),
      .rem  (core_rem_s)
   );

   assign hs_s = (state_r == HOLD) && res_rdy_i;

   // Grant selection; a grant is only possible when the result path is free.
   always_comb begin
      pick_chk_s = 1'b0;
      gnt_s      = 1'b0;
      if (enc_req_i && chk_req_i) begin
         if (P_ARB_MODE == 1) begin
            pick_chk_s = 1'b1;
         end else begin
            pick_chk_s = ~last_chk_r;
         end
      end else if (chk_req_i) begin
         pick_chk_s = 1'b1;
      end else begin
         pick_chk_s = 1'b0;
      end
      if ((state_r == IDLE) || hs_s) begin
         gnt_s = enc_req_i || chk_req_i;
      end else begin
         gnt_s = 1'b0;
      end
   end

   assign enc_ack_o = gnt_s && !pick_chk_s;
   assign chk_ack_o = gnt_s && pick_chk_s;

   // Next-state logic for the IDLE/CALC/HOLD sequencer.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (gnt_s) state_nxt_s = CALC;
            else       state_nxt_s = IDLE;
         end
         CALC: state_nxt_s = HOLD;
         HOLD: begin
            if (gnt_s)          state_nxt_s = CALC;
            else if (res_rdy_i) state_nxt_s = IDLE;
            else                state_nxt_s = HOLD;
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_r <= IDLE;
      else       state_r <= state_nxt_s;
   end

   // Operand capture on grant, result capture in CALC.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         opnd_r     <= '0;
         src_r      <= SRC_ENC;
         last_chk_r <= 1'b1;
         res_src_r  <= SRC_ENC;
         res_dat_r  <= '0;
         res_synd_r <= '0;
         res_err_r  <= 1'b0;
      end else begin
         if (gnt_s) begin
            opnd_r     <= pick_chk_s ? chk_dat_i : {enc_dat_i, {PAR_W{1'b0}}};
            src_r      <= pick_chk_s ? SRC_CHK : SRC_ENC;
            last_chk_r <= pick_chk_s;
         end
         if (state_r == CALC) begin
            res_src_r  <= src_r;
            res_dat_r  <= (src_r == SRC_CHK) ? opnd_r : {opnd_r[N-1:PAR_W], core_rem_s};
            res_synd_r <= core_rem_s;
            res_err_r  <= (src_r == SRC_CHK) && (core_rem_s != '0);
         end
      end
   end

   // Saturating statistics; a clear beats a same-cycle increment.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         enc_cnt_r <= '0;
         err_cnt_r <= '0;
      end else if (cnt_clr_i) begin
         enc_cnt_r <= '0;
         err_cnt_r <= '0;
      end else begin
         if (hs_s && (res_src_r == SRC_ENC) && (enc_cnt_r != CNT_MAX)) begin
            enc_cnt_r <= enc_cnt_r + CNT_ONE;
         end
         if (hs_s && (res_src_r == SRC_CHK) && res_err_r && (err_cnt_r != CNT_MAX)) begin
            err_cnt_r <= err_cnt_r + CNT_ONE;
         end
      end
   end

   assign res_vld_o  = (state_r == HOLD);
   assign busy_o     = (state_r != IDLE);
   assign res_src_o  = res_src_r;
   assign res_dat_o  = res_dat_r;
   assign res_synd_o = res_synd_r;
   assign res_err_o  = res_err_r;
   assign enc_cnt_o  = enc_cnt_r;
   assign err_cnt_o  = err_cnt_r;

endmodule

// File: tb/tb_bch_enc_synd_arb.sv
// Directed bench: instance 0 is round-robin with 16-bit counters, instance 1 is
// check-priority with 2-bit counters; a scoreboard checks every result handshake.
module tb_bch_enc_synd_arb;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        enc_req [2];
   logic        chk_req [2];
   logic        res_rdy [2];
   logic        cnt_clr [2];
   logic [20:0] enc_dat [2];
   logic [30:0] chk_dat [2];
   logic        enc_ack [2];
   logic        chk_ack [2];
   logic        res_vld [2];
   logic        res_src [2];
   logic        res_err [2];
   logic        busy    [2];
   logic [30:0] res_dat [2];
   logic [9:0]  res_synd[2];
   logic [15:0] enc_cnt0, err_cnt0;
   logic [1:0]  enc_cnt1, err_cnt1;

   bch_enc_synd_arb #(.P_CNT_W(16), .P_ARB_MODE(0)) u_dut0 (
      .clk_i(clk), .rst_i(rst),
      .enc_req_i(enc_req[0]), .enc_dat_i(enc_dat[0]), .enc_ack_o(enc_ack[0]),
      .chk_req_i(chk_req[0]), .chk_dat_i(chk_dat[0]), .chk_ack_o(chk_ack[0]),
      .res_vld_o(res_vld[0]), .res_rdy_i(res_rdy[0]), .res_src_o(res_src[0]),
      .res_dat_o(res_dat[0]), .res_synd_o(res_synd[0]), .res_err_o(res_err[0]),
      .busy_o(busy[0]), .cnt_clr_i(cnt_clr[0]),
      .enc_cnt_o(enc_cnt0), .err_cnt_o(err_cnt0)
   );

   bch_enc_synd_arb #(.P_CNT_W(2), .P_ARB_MODE(1)) u_dut1 (
      .clk_i(clk), .rst_i(rst),
      .enc_req_i(enc_req[1]), .enc_dat_i(enc_dat[1]), .enc_ack_o(enc_ack[1]),
      .chk_req_i(chk_req[1]), .chk_dat_i(chk_dat[1]), .chk_ack_o(chk_ack[1]),
      .res_vld_o(res_vld[1]), .res_rdy_i(res_rdy[1]), .res_src_o(res_src[1]),
      .res_dat_o(res_dat[1]), .res_synd_o(res_synd[1]), .res_err_o(res_err[1]),
      .busy_o(busy[1]), .cnt_clr_i(cnt_clr[1]),
      .enc_cnt_o(enc_cnt1), .err_cnt_o(err_cnt1)
   );

   typedef struct {
      int          dut;
      logic        src;
      logic [30:0] dat;
      logic [9:0]  synd;
      logic        err;
      int          cyc;
   } exp_t;

   exp_t        exp_q[$];
   logic        gsrc0[$];
   logic        gsrc1[$];
   int          gcyc0[$];
   int          gcyc1[$];
   int          n_cmp  = 0;
   int          n_fail = 0;
   int          cyc    = 0;
   logic        prev_vld[2];
   logic [30:0] last_dat[2];
   logic [9:0]  last_synd[2];
   logic        last_err[2];
   logic        last_src[2];
   exp_t        mon_e;
   int          mon_idx;

   function automatic void check1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0b, want %0b", tag, obs, exp);
      end
   endfunction

   function automatic void check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endfunction

   // Reference remainder by XOR-ing shifted copies of g(x) under each leading one.
   function automatic logic [9:0] tb_rem(input logic [30:0] w);
      logic [30:0] r;
      logic [30:0] g;
      r = w;
      for (int i = 30; i >= 10; i--) begin
         if (r[i]) begin
            g = 31'(11'h769) << (i - 10);
            r = r ^ g;
         end
      end
      return r[9:0];
   endfunction

   function automatic int find_first(input int k);
      for (int i = 0; i < exp_q.size(); i++) begin
         if (exp_q[i].dut == k) return i;
      end
      return -1;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: push on ack, check latency on valid rise, pop on handshake.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         prev_vld[0] = 1'b0;
         prev_vld[1] = 1'b0;
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (enc_ack[k] || chk_ack[k]) begin
               check1("ack_excl", enc_ack[k] & chk_ack[k], 1'b0);
               check1("ack_state", !busy[k] || (res_vld[k] && res_rdy[k]), 1'b1);
               mon_e.dut = k;
               mon_e.cyc = cyc;
               mon_e.src = chk_ack[k];
               if (chk_ack[k]) begin
                  mon_e.dat  = chk_dat[k];
                  mon_e.synd = tb_rem(chk_dat[k]);
                  mon_e.err  = (mon_e.synd != 10'd0);
               end else begin
                  mon_e.synd = tb_rem({enc_dat[k], 10'd0});
                  mon_e.dat  = {enc_dat[k], mon_e.synd};
                  mon_e.err  = 1'b0;
               end
               exp_q.push_back(mon_e);
               if (k == 0) begin gsrc0.push_back(mon_e.src); gcyc0.push_back(cyc); end
               else        begin gsrc1.push_back(mon_e.src); gcyc1.push_back(cyc); end
            end
            mon_idx = find_first(k);
            if (res_vld[k] && !prev_vld[k]) begin
               if (mon_idx < 0) check1("sb_unexpected_vld", 1'b1, 1'b0);
               else check32("latency", 32'(cyc), 32'(exp_q[mon_idx].cyc + 2));
            end
            if (res_vld[k] && res_rdy[k] && mon_idx >= 0) begin
               check1("res_src", res_src[k], exp_q[mon_idx].src);
               check32("res_dat", 32'(res_dat[k]), 32'(exp_q[mon_idx].dat));
               check32("res_synd", 32'(res_synd[k]), 32'(exp_q[mon_idx].synd));
               check1("res_err", res_err[k], exp_q[mon_idx].err);
               last_dat[k]  = res_dat[k];
               last_synd[k] = res_synd[k];
               last_err[k]  = res_err[k];
               last_src[k]  = res_src[k];
               exp_q.delete(mon_idx);
            end
            prev_vld[k] = res_vld[k];
         end
      end
   end

   task automatic req_enc(input int k, input logic [20:0] d);
      int n;
      n = 0;
      @(posedge clk); #1;
      enc_dat[k] = d;
      enc_req[k] = 1'b1;
      do begin @(negedge clk); n++; end while (!enc_ack[k] && n < 50);
      check1("enc_ack_wait", enc_ack[k], 1'b1);
      @(posedge clk); #1;
      enc_req[k] = 1'b0;
   endtask

   task automatic req_chk(input int k, input logic [30:0] w);
      int n;
      n = 0;
      @(posedge clk); #1;
      chk_dat[k] = w;
      chk_req[k] = 1'b1;
      do begin @(negedge clk); n++; end while (!chk_ack[k] && n < 50);
      check1("chk_ack_wait", chk_ack[k], 1'b1);
      @(posedge clk); #1;
      chk_req[k] = 1'b0;
   endtask

   task automatic wait_idle(input int k);
      int n;
      n = 0;
      do begin @(negedge clk); n++; end while ((busy[k] || res_vld[k]) && n < 50);
      check1("idle_wait", busy[k], 1'b0);
   endtask

   task automatic hold_both(input int k, input int ng, input logic [20:0] ed,
                            input logic [30:0] cd, output int base);
      int n;
      int got;
      n   = 0;
      got = 0;
      @(posedge clk); #1;
      base       = (k == 0) ? gsrc0.size() : gsrc1.size();
      enc_dat[k] = ed;
      chk_dat[k] = cd;
      enc_req[k] = 1'b1;
      chk_req[k] = 1'b1;
      do begin
         @(negedge clk);
         n++;
         if (enc_ack[k] || chk_ack[k]) got++;
      end while (got < ng && n < 100);
      check32("tie_grants", 32'(got), 32'(ng));
      @(posedge clk); #1;
      enc_req[k] = 1'b0;
      chk_req[k] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          base;
      int          n;
      logic [9:0]  exp_s;
      rst = 1'b1;
      for (int k = 0; k < 2; k++) begin
         enc_req[k] = 1'b0; chk_req[k] = 1'b0; res_rdy[k] = 1'b1; cnt_clr[k] = 1'b0;
         enc_dat[k] = 21'd0; chk_dat[k] = 31'd0;
         prev_vld[k] = 1'b0;
      end
      repeat (3) @(negedge clk);
      check1("rst_vld", res_vld[0], 1'b0);
      check1("rst_busy", busy[0], 1'b0);
      check1("rst_ack", enc_ack[0] | chk_ack[0], 1'b0);
      check32("rst_dat", 32'(res_dat[0]), 32'd0);
      check32("rst_synd", 32'(res_synd[0]), 32'd0);
      check32("rst_cnt", 32'({enc_cnt0, err_cnt0}), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // encode of a single data one
      req_enc(0, 21'h000001);
      wait_idle(0);
      check32("enc1_synd", 32'(last_synd[0]), 32'h369);
      check32("enc1_dat", 32'(last_dat[0]), 32'h769);
      check1("enc1_src", last_src[0], 1'b0);
      check1("enc1_err", last_err[0], 1'b0);
      check32("enc1_cnt", 32'(enc_cnt0), 32'd1);

      // clean codeword then single-bit error
      req_chk(0, 31'h769);
      wait_idle(0);
      check32("chk_ok_synd", 32'(last_synd[0]), 32'd0);
      check1("chk_ok_err", last_err[0], 1'b0);
      req_chk(0, 31'h768);
      wait_idle(0);
      check32("chk_bad_synd", 32'(last_synd[0]), 32'h001);
      check1("chk_bad_err", last_err[0], 1'b1);
      check32("chk_bad_cnt", 32'(err_cnt0), 32'd1);

      // round-robin under continuous contention
      hold_both(0, 4, 21'h0A5A5A, 31'h769, base);
      wait_idle(0);
      for (int i = 0; i < 4; i++) begin
         check1("rr_order", gsrc0[base + i], (i % 2) == 1);
         check32("rr_spacing", 32'(gcyc0[base + i] - gcyc0[base]), 32'(2 * i));
      end

      // fixed priority: check always wins, feeding the 2-bit error counter
      hold_both(1, 3, 21'h0ABCDE, 31'h768, base);
      wait_idle(1);
      for (int i = 0; i < 3; i++) check1("prio_order", gsrc1[base + i], 1'b1);
      check32("sat_reach", 32'(err_cnt1), 32'd3);
      req_chk(1, 31'h1);
      wait_idle(1);
      req_chk(1, 31'h2);
      wait_idle(1);
      check32("sat_hold", 32'(err_cnt1), 32'd3);
      check32("prio_enc_cnt", 32'(enc_cnt1), 32'd0);

      // back-pressure while a check request waits
      @(posedge clk); #1;
      res_rdy[0] = 1'b0;
      req_enc(0, 21'h155AA);
      chk_dat[0] = 31'h768;
      chk_req[0] = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!res_vld[0] && n < 10);
      exp_s = tb_rem({21'h155AA, 10'd0});
      for (int i = 0; i < 5; i++) begin
         check1("stall_vld", res_vld[0], 1'b1);
         check1("stall_busy", busy[0], 1'b1);
         check1("stall_ack", enc_ack[0] | chk_ack[0], 1'b0);
         check32("stall_dat", 32'(res_dat[0]), 32'({21'h155AA, exp_s}));
         check32("stall_synd", 32'(res_synd[0]), 32'(exp_s));
         @(negedge clk);
      end
      @(posedge clk); #1;
      res_rdy[0] = 1'b1;
      @(negedge clk);
      check1("stall_release_ack", chk_ack[0], 1'b1);
      @(posedge clk); #1;
      chk_req[0] = 1'b0;
      wait_idle(0);
      check32("cnt_enc0", 32'(enc_cnt0), 32'd4);
      check32("cnt_err0", 32'(err_cnt0), 32'd2);

      // clear coinciding with a result handshake
      @(posedge clk); #1;
      res_rdy[1] = 1'b0;
      req_chk(1, 31'h3);
      @(posedge clk); #1;
      cnt_clr[1] = 1'b1;
      res_rdy[1] = 1'b1;
      @(posedge clk); #1;
      cnt_clr[1] = 1'b0;
      check32("clr_wins", 32'(err_cnt1), 32'd0);
      wait_idle(1);
      req_chk(1, 31'h768);
      wait_idle(1);
      check32("clr_recount", 32'(err_cnt1), 32'd1);

      // reset while a result is being computed
      req_enc(0, 21'h1F0F0);
      rst = 1'b1;
      #1;
      check1("arst_vld", res_vld[0], 1'b0);
      check1("arst_busy", busy[0], 1'b0);
      check32("arst_dat", 32'(res_dat[0]), 32'd0);
      check32("arst_synd", 32'(res_synd[0]), 32'd0);
      check32("arst_cnt", 32'({enc_cnt0, err_cnt0}), 32'd0);
      @(negedge clk);
      @(posedge clk); #1;
      rst = 1'b0;
      hold_both(0, 2, 21'h00F0F, 31'h769, base);
      wait_idle(0);
      check1("arst_first_tie", gsrc0[base], 1'b0);
      check1("arst_second_tie", gsrc0[base + 1], 1'b1);
      check32("arst_enc_cnt", 32'(enc_cnt0), 32'd1);
      check32("sb_drain", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
